// File: rtl/cla5_resp_checker.sv
// ---------------------------------------------------------------------------
// cla5_resp_checker
//
// Response checker for the 5-bit Manchester carry-lookahead adder.
// Each accepted vector carries the operands applied to the adder (a, b, cin)
// and the adder's observed result (s, cout). The vector is registered into a
// single compare stage. On the next edge it is checked against a behavioural
// golden sum, and the pass/fail counters are updated. The first mismatching
// vector of a session can optionally be captured.
//
// Optional feature macro: CLA5_CHK_FIRSTFAIL_EN
//    defined   : first_fail_idx / first_fail_exp capture registers are built
//    undefined : first_fail_idx / first_fail_exp are tied to zero
//
// Ports
//    clk            rising-edge clock
//    rst_n          asynchronous active-low reset
//    start          pulse: open a session, clear counters and captures
//    stop           pulse: close the session once the compare stage drains
//    in_valid       a vector is present on a/b/cin/s/cout
//    in_ready       the checker accepts a vector this cycle
//    a, b, cin      operands applied to the adder
//    s, cout        observed adder outputs
//    busy           session active (RUN or DRAIN)
//    done           session complete, verdict outputs stable
//    pass_cnt       number of matching vectors (saturating)
//    fail_cnt       number of mismatching vectors (saturating)
//    err_sticky     any mismatch seen in this session
//    first_fail_idx index of the first mismatching vector
//    first_fail_exp expected {cout,s} of the first mismatching vector
// ---------------------------------------------------------------------------
module cla5_resp_checker #(
   parameter int WIDTH = 5,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [WIDTH-1:0] s,
   input  logic             cout,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             err_sticky,
   output logic [CNT_W-1:0] first_fail_idx,
   output logic [WIDTH:0]   first_fail_exp
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state;
   state_t           next_state;
   logic             session_clear;
   logic             xfer;

   logic             c1_valid;
   logic [WIDTH-1:0] c1_a;
   logic [WIDTH-1:0] c1_b;
   logic             c1_cin;
   logic [WIDTH-1:0] c1_s;
   logic             c1_cout;
   logic [WIDTH:0]   c1_exp;
   logic             c1_match;

   assign xfer = in_valid & in_ready;

   // The golden sum is computed one bit wider than the operands, so the
   // carry-out is part of the comparison and nothing is truncated.
   assign c1_exp   = {1'b0, c1_a} + {1'b0, c1_b} + {{WIDTH{1'b0}}, c1_cin};
   assign c1_match = ({c1_cout, c1_s} == c1_exp);

   // Session state register. An asynchronous reset drops any session in
   // progress back to IDLE immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and handshake decode. start only opens a session from IDLE
   // or DONE, and it wins over a simultaneous stop. DRAIN lasts exactly one
   // cycle: in_ready is low there, so the only vector that can still sit in
   // the compare stage retires on the same edge that moves us to DONE. The
   // verdict is therefore final as soon as done rises.
   always_comb begin
      next_state    = state;
      in_ready      = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      session_clear = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state    = RUN;
               session_clear = 1'b1;
            end
         end
         RUN: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (stop) begin
               next_state = DRAIN;
            end
         end
         DRAIN: begin
            busy       = 1'b1;
            next_state = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               next_state    = RUN;
               session_clear = 1'b1;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Compare stage 1. Every accepted vector is captured here for one cycle.
   // The operand/result registers only load on a transfer; the valid flag
   // tracks whether the stage holds a vector that still has to be scored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c1_valid <= 1'b0;
         c1_a     <= '0;
         c1_b     <= '0;
         c1_cin   <= 1'b0;
         c1_s     <= '0;
         c1_cout  <= 1'b0;
      end else if (session_clear) begin
         c1_valid <= 1'b0;
      end else begin
         c1_valid <= xfer;
         if (xfer) begin
            c1_a    <= a;
            c1_b    <= b;
            c1_cin  <= cin;
            c1_s    <= s;
            c1_cout <= cout;
         end
      end
   end

   // Scoring. A vector leaving stage 1 bumps either the pass or the fail
   // counter. Both counters stick at all-ones rather than wrap, so a long
   // run never makes a failing session look clean.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass_cnt   <= '0;
         fail_cnt   <= '0;
         err_sticky <= 1'b0;
      end else if (session_clear) begin
         pass_cnt   <= '0;
         fail_cnt   <= '0;
         err_sticky <= 1'b0;
      end else if (c1_valid) begin
         if (c1_match) begin
            if (pass_cnt != CNT_MAX) begin
               pass_cnt <= pass_cnt + CNT_ONE;
            end
         end else begin
            err_sticky <= 1'b1;
            if (fail_cnt != CNT_MAX) begin
               fail_cnt <= fail_cnt + CNT_ONE;
            end
         end
      end
   end

`ifdef CLA5_CHK_FIRSTFAIL_EN
   logic [CNT_W-1:0] vec_idx;
   logic [CNT_W-1:0] c1_idx;
   logic [CNT_W-1:0] ff_idx;
   logic [WIDTH:0]   ff_exp;

   // Vector numbering. Each accepted vector is tagged with its position in
   // the session, and the tag travels with it through stage 1. The running
   // index saturates like the counters. It only feeds the first-fail
   // capture, so it is built only when that capture is present.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_idx <= '0;
         c1_idx  <= '0;
      end else if (session_clear) begin
         vec_idx <= '0;
         c1_idx  <= '0;
      end else if (xfer) begin
         c1_idx <= vec_idx;
         if (vec_idx != CNT_MAX) begin
            vec_idx <= vec_idx + CNT_ONE;
         end
      end
   end

   // First-fail capture. err_sticky is still low only while no mismatch has
   // been scored this session, so it doubles as the "capture armed" flag.
   // Later mismatches leave the captured vector untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff_idx <= '0;
         ff_exp <= '0;
      end else if (session_clear) begin
         ff_idx <= '0;
         ff_exp <= '0;
      end else if (c1_valid && !c1_match && !err_sticky) begin
         ff_idx <= c1_idx;
         ff_exp <= c1_exp;
      end
   end

   assign first_fail_idx = ff_idx;
   assign first_fail_exp = ff_exp;
`else
   assign first_fail_idx = '0;
   assign first_fail_exp = '0;
`endif

endmodule

// File: tb/tb_cla5_resp_checker.sv
// ---------------------------------------------------------------------------
// tb_cla5_resp_checker
//
// Self-checking bench for cla5_resp_checker. Two instances share the same
// stimulus: the default build (CNT_W=8) and a narrow build (CNT_W=2), which
// shows counter saturation. The expected values come from a queue of the
// vectors accepted in the current session. Each verdict is recomputed from
// plain integer arithmetic on that queue.
// ---------------------------------------------------------------------------
module tb_cla5_resp_checker;

   localparam int P_IDLE  = 0;
   localparam int P_RUN   = 1;
   localparam int P_DRAIN = 2;
   localparam int P_DONE  = 3;

   typedef struct packed {
      logic [4:0] a;
      logic [4:0] b;
      logic       cin;
      logic [4:0] s;
      logic       cout;
   } vec_t;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       start    = 1'b0;
   logic       stop     = 1'b0;
   logic       in_valid = 1'b0;
   logic [4:0] a        = '0;
   logic [4:0] b        = '0;
   logic       cin      = 1'b0;
   logic [4:0] s        = '0;
   logic       cout     = 1'b0;

   logic       in_ready;
   logic       busy;
   logic       done;
   logic [7:0] pass_cnt;
   logic [7:0] fail_cnt;
   logic       err_sticky;
   logic [7:0] first_fail_idx;
   logic [5:0] first_fail_exp;

   logic       in_ready2;
   logic       busy2;
   logic       done2;
   logic [1:0] pass_cnt2;
   logic [1:0] fail_cnt2;
   logic       err_sticky2;
   logic [1:0] first_fail_idx2;
   logic [5:0] first_fail_exp2;

   int   passCount  = 0;
   int   totalCount = 0;
   int   phase      = P_IDLE;
   vec_t vecQ[$];

   cla5_resp_checker #(.WIDTH(5), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .s(s), .cout(cout),
      .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
      .err_sticky(err_sticky), .first_fail_idx(first_fail_idx),
      .first_fail_exp(first_fail_exp)
   );

   cla5_resp_checker #(.WIDTH(5), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .in_valid(in_valid), .in_ready(in_ready2),
      .a(a), .b(b), .cin(cin), .s(s), .cout(cout),
      .busy(busy2), .done(done2), .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2),
      .err_sticky(err_sticky2), .first_fail_idx(first_fail_idx2),
      .first_fail_exp(first_fail_exp2)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports a mismatch.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      totalCount++;
      if (observed == expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Score the first n vectors of the session using integer arithmetic and
   // clamp the results at cmax (the all-ones value of the counter width).
   function automatic void summarize(input int n, input int cmax,
                                     output int p, output int f, output int e,
                                     output int fi, output int fx);
      int expSum;
      int obsSum;
      p = 0; f = 0; e = 0; fi = 0; fx = 0;
      for (int i = 0; i < n; i++) begin
         expSum = int'(vecQ[i].a) + int'(vecQ[i].b) + int'(vecQ[i].cin);
         obsSum = int'(vecQ[i].cout) * 32 + int'(vecQ[i].s);
         if (expSum == obsSum) begin
            p++;
         end else begin
            if (e == 0) begin
               fi = (i > cmax) ? cmax : i;
               fx = expSum;
            end
            e = 1;
            f++;
         end
      end
      if (p > cmax) p = cmax;
      if (f > cmax) f = cmax;
   endfunction

   // Compare both instances against the model. Only the first `retired`
   // vectors have left the compare stage.
   task automatic checkAll(input int retired);
      int p, f, e, fi, fx;
      summarize(retired, 255, p, f, e, fi, fx);
      checkOutput("in_ready", int'(in_ready), int'(phase == P_RUN));
      checkOutput("busy", int'(busy), int'(phase == P_RUN || phase == P_DRAIN));
      checkOutput("done", int'(done), int'(phase == P_DONE));
      checkOutput("pass_cnt", int'(pass_cnt), p);
      checkOutput("fail_cnt", int'(fail_cnt), f);
      checkOutput("err_sticky", int'(err_sticky), e);
`ifdef CLA5_CHK_FIRSTFAIL_EN
      checkOutput("first_fail_idx", int'(first_fail_idx), fi);
      checkOutput("first_fail_exp", int'(first_fail_exp), fx);
`else
      checkOutput("first_fail_idx", int'(first_fail_idx), 0);
      checkOutput("first_fail_exp", int'(first_fail_exp), 0);
`endif
      summarize(retired, 3, p, f, e, fi, fx);
      checkOutput("done_w2", int'(done2), int'(phase == P_DONE));
      checkOutput("pass_cnt_w2", int'(pass_cnt2), p);
      checkOutput("fail_cnt_w2", int'(fail_cnt2), f);
      checkOutput("err_sticky_w2", int'(err_sticky2), e);
`ifdef CLA5_CHK_FIRSTFAIL_EN
      checkOutput("first_fail_idx_w2", int'(first_fail_idx2), fi);
      checkOutput("first_fail_exp_w2", int'(first_fail_exp2), fx);
`else
      checkOutput("first_fail_idx_w2", int'(first_fail_idx2), 0);
      checkOutput("first_fail_exp_w2", int'(first_fail_exp2), 0);
`endif
   endtask

   // Drive one clock cycle of stimulus, advance the session model and check
   // the outputs 1 ns after the edge.
   task automatic applyStimulus(input bit st, input bit sp, input bit inv,
                                input logic [4:0] va, input logic [4:0] vb, input logic vc,
                                input logic [4:0] vs, input logic vco);
      vec_t v;
      int   accepted;
      start = st; stop = sp; in_valid = inv;
      a = va; b = vb; cin = vc; s = vs; cout = vco;
      accepted = (phase == P_RUN && inv) ? 1 : 0;
      if (accepted == 1) begin
         v.a = va; v.b = vb; v.cin = vc; v.s = vs; v.cout = vco;
         vecQ.push_back(v);
      end
      if ((phase == P_IDLE || phase == P_DONE) && st) begin
         vecQ.delete();
         phase = P_RUN;
      end else if (phase == P_RUN && sp) begin
         phase = P_DRAIN;
      end else if (phase == P_DRAIN) begin
         phase = P_DONE;
      end
      @(posedge clk);
      #1;
      start = 1'b0; stop = 1'b0; in_valid = 1'b0;
      checkAll(vecQ.size() - accepted);
   endtask

   task automatic sendVec(input int va, input int vb, input int vc, input int vs, input int vco);
      applyStimulus(1'b0, 1'b0, 1'b1, 5'(va), 5'(vb), 1'(vc), 5'(vs), 1'(vco));
   endtask

   task automatic pulse(input bit st, input bit sp);
      applyStimulus(st, sp, 1'b0, '0, '0, 1'b0, '0, 1'b0);
   endtask

   // Assert reset asynchronously and check that all outputs clear before the
   // next clock edge. Then release reset away from the edge.
   task automatic doReset();
      rst_n = 1'b0;
      #2;
      phase = P_IDLE;
      vecQ.delete();
      checkAll(0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Directed scenarios first, then a randomized session stream.
   initial begin
      int ra, rb, rc, sum;
      bit st, sp, inv;
      $display("[TB] starting cla5_resp_checker bench");

      doReset();

      // Four correct vectors back-to-back, then stop; done rises two edges later.
      pulse(1'b1, 1'b0);
      sendVec(3, 5, 0, 5'b01000, 0);
      sendVec(31, 7, 0, 5'b00110, 1);
      sendVec(10, 14, 0, 5'b11000, 0);
      sendVec(28, 28, 1, 5'b11001, 1);
      pulse(1'b0, 1'b1);
      pulse(1'b0, 1'b0);
      checkOutput("tp1_pass_cnt", int'(pass_cnt), 4);
      checkOutput("tp1_done", int'(done), 1);

      // Restart from DONE. Vector 3 carries a wrong sum.
      pulse(1'b1, 1'b0);
      sendVec(3, 5, 0, 5'b01000, 0);
      sendVec(31, 7, 0, 5'b00110, 1);
      sendVec(10, 14, 0, 5'b11000, 0);
      sendVec(28, 28, 1, 5'b11000, 1);
      pulse(1'b0, 1'b1);
      pulse(1'b0, 1'b0);
      checkOutput("tp2_fail_cnt", int'(fail_cnt), 1);
`ifdef CLA5_CHK_FIRSTFAIL_EN
      checkOutput("tp2_ff_idx", int'(first_fail_idx), 3);
      checkOutput("tp2_ff_exp", int'(first_fail_exp), 57);
`else
      checkOutput("tp2_ff_idx", int'(first_fail_idx), 0);
      checkOutput("tp2_ff_exp", int'(first_fail_exp), 0);
`endif

      // Mismatches at vectors 1 and 2. The last vector arrives with stop.
      pulse(1'b1, 1'b0);
      sendVec(1, 2, 0, 3, 0);
      sendVec(4, 4, 0, 9, 0);
      sendVec(30, 1, 1, 0, 0);
      applyStimulus(1'b0, 1'b1, 1'b1, 5'd2, 5'd2, 1'b0, 5'd4, 1'b0);
      pulse(1'b0, 1'b0);
      checkOutput("tp3_fail_cnt", int'(fail_cnt), 2);
      checkOutput("tp3_pass_cnt", int'(pass_cnt), 2);
      checkOutput("tp3_done", int'(done), 1);
`ifdef CLA5_CHK_FIRSTFAIL_EN
      checkOutput("tp3_ff_idx", int'(first_fail_idx), 1);
`else
      checkOutput("tp3_ff_idx", int'(first_fail_idx), 0);
`endif

      // When start and stop arrive together in IDLE, start wins. Then five
      // passing vectors saturate the narrow counter.
      doReset();
      pulse(1'b1, 1'b1);
      checkOutput("tp4_busy", int'(busy), 1);
      for (int i = 0; i < 5; i++) begin
         sendVec(i, i + 1, 0, 2 * i + 1, 0);
      end
      pulse(1'b0, 1'b0);
      checkOutput("tp5_pass_w2_sat", int'(pass_cnt2), 3);
      checkOutput("tp5_pass", int'(pass_cnt), 5);
      pulse(1'b0, 1'b1);
      pulse(1'b0, 1'b0);

      // Reset while a vector sits in the compare stage, then a fresh session.
      pulse(1'b1, 1'b0);
      sendVec(1, 1, 0, 2, 0);
      sendVec(2, 1, 0, 3, 0);
      doReset();
      pulse(1'b1, 1'b0);
      sendVec(0, 0, 0, 0, 0);
      pulse(1'b0, 1'b0);
      checkOutput("tp6_pass_cnt", int'(pass_cnt), 1);
      pulse(1'b0, 1'b1);
      pulse(1'b0, 1'b0);

      // Randomized stream: sparse start/stop pulses, gaps in in_valid and
      // occasional corrupted results.
      for (int n = 0; n < 400; n++) begin
         st  = ($urandom_range(0, 15) == 0);
         sp  = ($urandom_range(0, 11) == 0);
         inv = ($urandom_range(0, 3) != 0);
         ra  = $urandom_range(0, 31);
         rb  = $urandom_range(0, 31);
         rc  = $urandom_range(0, 1);
         sum = ra + rb + rc;
         if ($urandom_range(0, 4) == 0) begin
            sum = sum ^ $urandom_range(1, 63);
         end
         applyStimulus(st, sp, inv, 5'(ra), 5'(rb), 1'(rc), 5'(sum), 1'(sum >> 5));
      end

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
